filter_stream_driver: RTL

- Host-side companion to the moving-average filter. It is the initiator and collector at the far end of the filter's sample/result handshake.
- It buffers incoming samples in a small FIFO and issues each one to the filter as a single-cycle data_valid pulse, but only while the filter reports data_ready.
- It tracks the filter's busy/compute window with a timeout, and captures every result_valid pulse into a result FIFO with a valid/ready output stream.

---
 rtl/filter_stream_driver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/filter_stream_driver.sv
// Host-side driver for the moving-average filter: queues samples, issues them as
// single-cycle data_valid pulses, watches the busy window and collects results.
module filter_stream_driver #(
  parameter int DATA_WIDTH     = 8,
  parameter int SFIFO_DEPTH    = 4,
  parameter int RFIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_num_taps,
  input  logic                  clr_err,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  flt_enable,
  output logic [3:0]            flt_num_taps,
  output logic                  flt_data_valid,
  output logic [DATA_WIDTH-1:0] flt_data_in,
  input  logic                  flt_data_ready,
  input  logic                  flt_busy,
  input  logic                  flt_result_valid,
  input  logic [DATA_WIDTH-1:0] flt_result,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  timeout_err,
  output logic                  overflow_err,
  output logic [1:0]            state
);

  localparam int SAW = $clog2(SFIFO_DEPTH);
  localparam int RAW = $clog2(RFIFO_DEPTH);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ISSUE    = 2'b01,
    SETTLE   = 2'b10,
    WAIT_RES = 2'b11
  } state_t;

  state_t                st;
  logic [TW-1:0]         timer;

  logic [DATA_WIDTH-1:0] smem [SFIFO_DEPTH];
  logic [SAW:0]          s_wr, s_rd;
  logic                  s_empty, s_full, s_push, s_pop;

  logic [DATA_WIDTH-1:0] rmem [RFIFO_DEPTH];
  logic [RAW:0]          r_wr, r_rd;
  logic                  r_empty, r_full, r_push, r_pop, ovf_evt, tmo_evt;

  // Sample FIFO: pointers carry one extra wrap bit so full/empty need no counter.
  assign s_empty = (s_wr == s_rd);
  assign s_full  = (s_wr[SAW] != s_rd[SAW]) && (s_wr[SAW-1:0] == s_rd[SAW-1:0]);
  assign s_ready = !s_full;
  assign s_push  = s_valid && !s_full;
  assign s_pop   = (st == ISSUE) && cfg_enable;

  always_ff @(posedge clk) begin
    if (s_push) smem[s_wr[SAW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_wr <= '0;
      s_rd <= '0;
    end else begin
      if (s_push) s_wr <= s_wr + 1'b1;
      if (s_pop)  s_rd <= s_rd + 1'b1;
    end
  end

  assign flt_enable     = cfg_enable;
  assign flt_data_valid = (st == ISSUE);
  assign flt_data_in    = (st == ISSUE) ? smem[s_rd[SAW-1:0]] : '0;
  assign state          = st;

  assign tmo_evt = (st == WAIT_RES) && flt_busy && !flt_result_valid &&
                   (timer == TW'(TIMEOUT_CYCLES - 1));

  // Issue FSM: one pulse per sample, then a guard cycle before watching busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      timer        <= '0;
      flt_num_taps <= '0;
      timeout_err  <= 1'b0;
    end else begin
      timeout_err <= tmo_evt || (timeout_err && !clr_err);
      case (st)
        IDLE: begin
          flt_num_taps <= cfg_num_taps;
          if (cfg_enable && flt_data_ready && !s_empty) st <= ISSUE;
        end
        ISSUE:  st <= cfg_enable ? SETTLE : IDLE;
        SETTLE: begin
          timer <= '0;
          st    <= flt_busy ? WAIT_RES : IDLE;
        end
        WAIT_RES: begin
          if (flt_result_valid || !flt_busy || tmo_evt) st <= IDLE;
          else timer <= timer + 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Result FIFO: a push into a full FIFO survives only if a pop frees a slot.
  assign r_empty = (r_wr == r_rd);
  assign r_full  = (r_wr[RAW] != r_rd[RAW]) && (r_wr[RAW-1:0] == r_rd[RAW-1:0]);
  assign m_valid = !r_empty;
  assign m_data  = r_empty ? '0 : rmem[r_rd[RAW-1:0]];
  assign r_pop   = m_valid && m_ready;
  assign r_push  = flt_result_valid && (!r_full || r_pop);
  assign ovf_evt = flt_result_valid && r_full && !r_pop;

  always_ff @(posedge clk) begin
    if (r_push) rmem[r_wr[RAW-1:0]] <= flt_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr         <= '0;
      r_rd         <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (r_push) r_wr <= r_wr + 1'b1;
      if (r_pop)  r_rd <= r_rd + 1'b1;
      overflow_err <= ovf_evt || (overflow_err && !clr_err);
    end
  end

endmodule
